// File: rtl/regfile_write_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Shares the single register-file write port between the in-order
//            writeback path and a buffered long-latency result source.
//            Pipeline writes always win the port. Buffered results drain into
//            idle slots. A starvation counter raises a pipeline stall request
//            when the buffer head cannot drain.
// Ports    : i_aclk / i_reset        clock, synchronous active-high reset
//            i_wb_*                  pipeline writeback request
//            i_lu_* / o_lu_ready     long-latency result valid/ready channel
//            o_rf_*                  registered register-file write port
//            o_stall_pipe            registered pipeline bubble request
//            o_pending               registers targeted by live buffered results
//            o_fifo_count            buffer occupancy (live and dead entries)
// Revision : 1.0  initial release
// ============================================================================
module regfile_write_arbiter #(
  parameter int NUM_REGS     = 32,
  parameter int DATA_SIZE    = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                          i_aclk,
  input  logic                          i_reset,
  input  logic                          i_wb_we,
  input  logic [$clog2(NUM_REGS)-1:0]   i_wb_rdest,
  input  logic [DATA_SIZE-1:0]          i_wb_data,
  input  logic                          i_lu_valid,
  output logic                          o_lu_ready,
  input  logic [$clog2(NUM_REGS)-1:0]   i_lu_rdest,
  input  logic [DATA_SIZE-1:0]          i_lu_data,
  output logic                          o_rf_we,
  output logic [$clog2(NUM_REGS)-1:0]   o_rf_waddr,
  output logic [DATA_SIZE-1:0]          o_rf_wdata,
  output logic                          o_stall_pipe,
  output logic [NUM_REGS-1:0]           o_pending,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int AW    = $clog2(NUM_REGS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SW    = $clog2(STARVE_LIMIT + 1);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [SW-1:0]    LIMIT_C = SW'(STARVE_LIMIT);

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } state_t;

  // Buffer storage. Payload is not reset; a slot only matters while its
  // live bit is set, and live bits are cleared by reset and on every pop.
  logic [AW-1:0]        rdest_mem [FIFO_DEPTH];
  logic [DATA_SIZE-1:0] data_mem  [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] live, live_nxt;
  logic [PTR_W-1:0]     rd_ptr, wr_ptr;
  logic [CNT_W-1:0]     count, count_nxt;
  logic [SW-1:0]        starve_cnt, starve_nxt;
  state_t               state, state_nxt;

  logic wbv, push, not_empty, head_live, head_dead, pop_live, pop;

  assign o_lu_ready   = (count < DEPTH_C);
  assign o_fifo_count = count;
  assign o_stall_pipe = (state == ST_FORCE);

  assign wbv       = i_wb_we && (i_wb_rdest != '0);
  // A transfer to register 0 is acknowledged but never enqueued.
  assign push      = i_lu_valid && o_lu_ready && (i_lu_rdest != '0);
  assign not_empty = (count != '0);
  assign head_live = not_empty &&  live[rd_ptr];
  assign head_dead = not_empty && !live[rd_ptr];
  // Pipeline writes block only live pops; dead heads are skipped regardless.
  assign pop_live  = head_live && !wbv;
  assign pop       = pop_live || head_dead;

  assign count_nxt = count + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};

  // Live-bit update: a pipeline write kills older results to the same
  // register (WAW), including a result arriving in this very cycle.
  always_comb begin
    live_nxt = live;
    if (wbv) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (rdest_mem[i] == i_wb_rdest) live_nxt[i] = 1'b0;
      end
    end
    if (pop)  live_nxt[rd_ptr] = 1'b0;
    if (push) live_nxt[wr_ptr] = !(wbv && (i_lu_rdest == i_wb_rdest));
  end

  // Starvation counter: counts cycles a live head is held off the port.
  always_comb begin
    starve_nxt = starve_cnt;
    if (!not_empty || pop_live) begin
      starve_nxt = '0;
    end else if (head_live && (starve_cnt < LIMIT_C)) begin
      starve_nxt = starve_cnt + SW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_NORMAL: if (starve_nxt == LIMIT_C) state_nxt = ST_FORCE;
      ST_FORCE:  if (pop_live || (count_nxt == '0)) state_nxt = ST_NORMAL;
      default:   state_nxt = ST_NORMAL;
    endcase
  end

  always_comb begin
    o_pending = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (live[i]) o_pending[rdest_mem[i]] = 1'b1;
    end
    o_pending[0] = 1'b0;
  end

  always_ff @(posedge i_aclk) begin
    if (i_reset) begin
      state <= ST_NORMAL;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_aclk) begin
    if (push) begin
      rdest_mem[wr_ptr] <= i_lu_rdest;
      data_mem[wr_ptr]  <= i_lu_data;
    end
  end

  always_ff @(posedge i_aclk) begin
    if (i_reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      live       <= '0;
      starve_cnt <= '0;
      o_rf_we    <= 1'b0;
      o_rf_waddr <= '0;
      o_rf_wdata <= '0;
    end else begin
      live       <= live_nxt;
      count      <= count_nxt;
      starve_cnt <= starve_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      // Address/data hold their last value when no write is issued.
      if (wbv) begin
        o_rf_we    <= 1'b1;
        o_rf_waddr <= i_wb_rdest;
        o_rf_wdata <= i_wb_data;
      end else if (pop_live) begin
        o_rf_we    <= 1'b1;
        o_rf_waddr <= rdest_mem[rd_ptr];
        o_rf_wdata <= data_mem[rd_ptr];
      end else begin
        o_rf_we    <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Purpose  : Directed bench for regfile_write_arbiter. Expected register-file
//            writes are queued when stimulus is driven and compared in order
//            as the write port fires; state outputs are checked at fixed points.
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_write_arbiter;

  logic        aclk = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_rdest;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rdest;
  logic [31:0] lu_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_pipe;
  logic [31:0] pending;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];

  regfile_write_arbiter #(
    .NUM_REGS(32), .DATA_SIZE(32), .FIFO_DEPTH(4), .STARVE_LIMIT(8)
  ) dut (
    .i_aclk(aclk), .i_reset(reset),
    .i_wb_we(wb_we), .i_wb_rdest(wb_rdest), .i_wb_data(wb_data),
    .i_lu_valid(lu_valid), .o_lu_ready(lu_ready),
    .i_lu_rdest(lu_rdest), .i_lu_data(lu_data),
    .o_rf_we(rf_we), .o_rf_waddr(rf_waddr), .o_rf_wdata(rf_wdata),
    .o_stall_pipe(stall_pipe), .o_pending(pending), .o_fifo_count(fifo_count)
  );

  always #5 aclk = ~aclk;

  function automatic logic [63:0] pack(input logic [4:0] a, input logic [31:0] d);
    return {27'd0, a, d};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle();
    wb_we = 1'b0; wb_rdest = '0; wb_data = '0;
    lu_valid = 1'b0; lu_rdest = '0; lu_data = '0;
  endtask

  // Scoreboard: every write-port pulse must match the oldest expected write.
  always @(negedge aclk) begin
    if (rf_we) begin
      if (sb.size() == 0) begin
        chk("rf_unexpected_we", {32'd0, 27'd0, rf_waddr}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        chk("rf_write", pack(rf_waddr, rf_wdata), sb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle();
    reset = 1'b1;
    tick(); tick();
    chk("reset_rf_we",   rf_we, 0);
    chk("reset_count",   fifo_count, 0);
    chk("reset_pending", pending, 0);
    chk("reset_stall",   stall_pipe, 0);
    chk("reset_ready",   lu_ready, 1);
    reset = 1'b0;
    tick();

    // Single long-latency result on an idle port.
    lu_valid = 1'b1; lu_rdest = 5'd5; lu_data = 32'hA5A5;
    sb.push_back(pack(5'd5, 32'hA5A5));
    tick();
    chk("t1_pending5", pending, 32'h0000_0020);
    chk("t1_count1",   fifo_count, 1);
    idle();
    tick();
    chk("t1_rf_we",       rf_we, 1);
    chk("t1_pending_clr", pending, 0);
    chk("t1_count0",      fifo_count, 0);
    tick();
    chk("t1_rf_we_idle", rf_we, 0);

    // Fill the buffer under continuous pipeline writes, then drain in order.
    for (int i = 0; i < 4; i++) begin
      wb_we = 1'b1; wb_rdest = 5'd9; wb_data = 32'h900 + i;
      lu_valid = 1'b1; lu_rdest = 5'(i + 1); lu_data = 32'h100 + i;
      sb.push_back(pack(5'd9, 32'h900 + i));
      tick();
    end
    chk("t2_count_full", fifo_count, 4);
    chk("t2_ready_full", lu_ready, 0);
    chk("t2_pending",    pending, 32'h0000_001E);
    idle();
    for (int i = 0; i < 4; i++) sb.push_back(pack(5'(i + 1), 32'h100 + i));
    tick();
    chk("t2_ready_after_pop", lu_ready, 1);
    chk("t2_count3",          fifo_count, 3);
    tick(); tick(); tick();
    chk("t2_drained", fifo_count, 0);
    tick();

    // Younger pipeline write kills an older buffered result.
    lu_valid = 1'b1; lu_rdest = 5'd7; lu_data = 32'h77;
    tick();
    chk("t3_pending7", pending, 32'h0000_0080);
    idle();
    wb_we = 1'b1; wb_rdest = 5'd7; wb_data = 32'h11;
    sb.push_back(pack(5'd7, 32'h11));
    tick();
    chk("t3_killed",    pending, 0);
    chk("t3_dead_held", fifo_count, 1);
    idle();
    tick();
    chk("t3_dead_popped", fifo_count, 0);
    chk("t3_dead_no_we",  rf_we, 0);

    // Same-cycle enqueue and pipeline write to one register.
    wb_we = 1'b1; wb_rdest = 5'd6; wb_data = 32'h22;
    lu_valid = 1'b1; lu_rdest = 5'd6; lu_data = 32'h66;
    sb.push_back(pack(5'd6, 32'h22));
    tick();
    chk("t3b_count1",  fifo_count, 1);
    chk("t3b_pending", pending, 0);
    idle();
    tick();
    chk("t3b_count0", fifo_count, 0);
    chk("t3b_no_we",  rf_we, 0);

    // Starvation: head held off for STARVE_LIMIT cycles raises the stall.
    for (int i = 0; i < 9; i++) begin
      wb_we = 1'b1; wb_rdest = 5'd8; wb_data = 32'h800 + i;
      lu_valid = (i == 0); lu_rdest = 5'd3; lu_data = 32'h33;
      sb.push_back(pack(5'd8, 32'h800 + i));
      tick();
      if (i == 7) chk("t4_no_stall_yet", stall_pipe, 0);
    end
    chk("t4_stall",     stall_pipe, 1);
    chk("t4_pending3",  pending, 32'h0000_0008);
    idle();
    sb.push_back(pack(5'd3, 32'h33));
    tick();
    chk("t4_stall_clr", stall_pipe, 0);
    chk("t4_count0",    fifo_count, 0);

    // Register 0 on both sources.
    chk("t5_ready", lu_ready, 1);
    lu_valid = 1'b1; lu_rdest = 5'd0; lu_data = 32'hDEAD;
    tick();
    chk("t5_count0",   fifo_count, 0);
    chk("t5_no_we",    rf_we, 0);
    chk("t5_hold",     pack(rf_waddr, rf_wdata), pack(5'd3, 32'h33));
    idle();
    wb_we = 1'b1; wb_rdest = 5'd0; wb_data = 32'hBEEF;
    tick();
    chk("t5_wb_r0_no_we", rf_we, 0);

    // Reset with buffered results discards them.
    for (int i = 0; i < 3; i++) begin
      wb_we = 1'b1; wb_rdest = 5'd13; wb_data = 32'hD00 + i;
      lu_valid = 1'b1; lu_rdest = 5'(10 + i); lu_data = 32'hA00 + i;
      sb.push_back(pack(5'd13, 32'hD00 + i));
      tick();
    end
    chk("t6_count3", fifo_count, 3);
    idle();
    reset = 1'b1;
    tick();
    chk("t6_count",   fifo_count, 0);
    chk("t6_pending", pending, 0);
    chk("t6_rf_we",   rf_we, 0);
    chk("t6_stall",   stall_pipe, 0);
    reset = 1'b0;
    repeat (5) tick();
    chk("t6_still_empty", fifo_count, 0);

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
